// File: rtl/stream_pkg.sv
// Shared sizing helpers for the stream packer/unpacker family.
package stream_pkg;

    localparam int MAX_RATIO = 16;

    // Wide enough for the largest legal ratio; narrower packers use the low bits.
    typedef logic [MAX_RATIO-1:0] keep_t;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int out_width(input int dw, input int ratio);
        return dw * ratio;
    endfunction

endpackage

// File: rtl/stream_packer.sv
// Packs RATIO narrow beats into one little-endian wide word behind a valid/ready port.
// Optional partial-word flush (in_last/out_keep) is built when STREAM_PACKER_FLUSH_EN is defined.
module stream_packer
    import stream_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int RATIO = 4,
    localparam int OUT_WIDTH = out_width(DATA_WIDTH, RATIO)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
`ifdef STREAM_PACKER_FLUSH_EN
    input  logic                  in_last,
    output logic [RATIO-1:0]      out_keep,
`endif
    output logic                  out_valid,
    output logic [OUT_WIDTH-1:0]  out_data,
    input  logic                  out_ready
);

    localparam int CW = clog2_min1(RATIO);
    localparam logic [CW-1:0] LAST_SLOT = CW'(RATIO - 1);

    logic [CW-1:0]        count_reg;
    logic                 out_valid_reg;
    logic [OUT_WIDTH-1:0] out_data_reg;
    logic [OUT_WIDTH-1:0] word_next;
    logic                 last_beat;
    logic                 full;
    logic                 take;
    logic                 complete;
    logic                 out_fire;

`ifdef STREAM_PACKER_FLUSH_EN
    logic [RATIO-1:0] keep_reg;
    logic [RATIO-1:0] keep_next;
    assign last_beat = in_last;
`else
    assign last_beat = 1'b0;
`endif

    assign full     = (count_reg == LAST_SLOT);
    // A completing beat can only enter if the output register is free or draining now.
    assign in_ready = (!full && !last_beat) || !out_valid_reg || out_ready;
    assign take     = in_valid && in_ready;
    assign complete = take && (full || last_beat);
    assign out_fire = out_valid_reg && out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < RATIO; gi++) begin : g_slot
            if (gi < RATIO - 1) begin : g_acc
                logic [DATA_WIDTH-1:0] slot_reg;

                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        slot_reg <= '0;
                    end else if (take && !complete && (count_reg == CW'(gi))) begin
                        slot_reg <= in_data;
                    end
                end

                // Slots beyond the current beat are zero so a flushed word is clean.
                assign word_next[gi*DATA_WIDTH +: DATA_WIDTH] =
                    (CW'(gi) < count_reg)  ? slot_reg :
                    (CW'(gi) == count_reg) ? in_data  : '0;
            end else begin : g_top
                assign word_next[gi*DATA_WIDTH +: DATA_WIDTH] = full ? in_data : '0;
            end
`ifdef STREAM_PACKER_FLUSH_EN
            assign keep_next[gi] = (CW'(gi) <= count_reg);
`endif
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg     <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
`ifdef STREAM_PACKER_FLUSH_EN
            keep_reg      <= '0;
`endif
        end else if (complete) begin
            count_reg     <= '0;
            out_valid_reg <= 1'b1;
            out_data_reg  <= word_next;
`ifdef STREAM_PACKER_FLUSH_EN
            keep_reg      <= keep_next;
`endif
        end else begin
            if (take) begin
                count_reg <= count_reg + CW'(1);
            end
            if (out_fire) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
`ifdef STREAM_PACKER_FLUSH_EN
    assign out_keep  = keep_reg;
`endif

endmodule

// File: tb/tb_stream_packer.sv
// Self-checking bench for stream_packer: queue-based word model plus directed literal checks.
module tb_stream_packer;

    localparam int R = 4;
`ifdef STREAM_PACKER_FLUSH_EN
    localparam bit FLUSH = 1'b1;
`else
    localparam bit FLUSH = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready = 1'b0;
`ifdef STREAM_PACKER_FLUSH_EN
    logic [3:0]  out_keep;
`endif

    int total = 0;
    int bad = 0;

    stream_packer #(.DATA_WIDTH(8), .RATIO(R)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
`ifdef STREAM_PACKER_FLUSH_EN
        .in_last   (in_last),
        .out_keep  (out_keep),
`endif
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: beats accepted so far for the open word, plus the word currently on offer.
    logic [7:0]  mbeats[$];
    logic        mvalid = 1'b0;
    logic [31:0] mword = '0;
    logic [3:0]  mkeep = '0;
    int          words_out = 0;

    always @(negedge clk) begin
        logic exp_ready;
        logic lst;
        if (!reset_n) begin
            mbeats.delete();
            mvalid = 1'b0;
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_out_data", 64'(out_data), 64'd0);
        end else begin
            lst = FLUSH && in_last;
            exp_ready = !mvalid || out_ready || (!lst && mbeats.size() != R - 1);
            chk("in_ready", 64'(in_ready), 64'(exp_ready));
            chk("out_valid", 64'(out_valid), 64'(mvalid));
            if (mvalid) begin
                chk("out_data", 64'(out_data), 64'(mword));
`ifdef STREAM_PACKER_FLUSH_EN
                chk("out_keep", 64'(out_keep), 64'(mkeep));
`endif
            end
            if (mvalid && out_ready) begin
                words_out++;
                mvalid = 1'b0;
            end
            if (in_valid && exp_ready) begin
                mbeats.push_back(in_data);
                if (mbeats.size() == R || lst) begin
                    mword = '0;
                    foreach (mbeats[i]) mword[i*8 +: 8] = mbeats[i];
                    mkeep = 4'((1 << mbeats.size()) - 1);
                    mvalid = 1'b1;
                    mbeats.delete();
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the beat has been taken.
    task automatic send(input logic [7:0] d, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_data = d;
        in_last = last;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready stuck 0 want 1 for beat 0x%0h", d);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: sim time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int stalls;
        int w0;
        int acc;
        int cycles;

        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_data", 64'(out_data), 64'd0);
        @(posedge clk);
        #1;

        // First word, downstream always ready: valid for exactly one cycle.
        out_ready = 1'b1;
        send(8'hA5, 1'b0);
        send(8'h5A, 1'b0);
        send(8'h3C, 1'b0);
        chk("w1_not_yet_valid", 64'(out_valid), 64'd0);
        send(8'hC3, 1'b0);
        chk("w1_valid", 64'(out_valid), 64'd1);
        chk("w1_data", 64'(out_data), 64'hC33C5AA5);
        @(posedge clk);
        #1;
        chk("w1_valid_one_cycle", 64'(out_valid), 64'd0);

        // Backpressure: word held, three more beats fit, the fourth stalls.
        out_ready = 1'b0;
        send(8'hA5, 1'b0);
        send(8'h5A, 1'b0);
        send(8'h3C, 1'b0);
        send(8'hC3, 1'b0);
        chk("hold_valid", 64'(out_valid), 64'd1);
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        in_valid = 1'b1;
        in_data = 8'h04;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_data", 64'(out_data), 64'hC33C5AA5);
            chk("stall_valid", 64'(out_valid), 64'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("reload_valid", 64'(out_valid), 64'd1);
        chk("reload_data", 64'(out_data), 64'h04030201);
        @(posedge clk);
        #1;
        chk("reload_drained", 64'(out_valid), 64'd0);

        // Full-rate burst: 4000 beats, downstream always ready.
        stalls = 0;
        w0 = words_out;
        for (int i = 0; i < 4000; i++) begin
            in_valid = 1'b1;
            in_data = 8'($urandom);
            @(negedge clk);
            if (!in_ready) stalls++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("burst_stalls", 64'(stalls), 64'd0);
        chk("burst_words", 64'(words_out - w0), 64'd1000);

        // Random valid/ready traffic, 32000 accepted beats.
        acc = 0;
        cycles = 0;
        w0 = words_out;
        while (acc < 32000 && cycles < 80000) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (in_valid && in_ready) acc++;
            @(posedge clk);
            #1;
            cycles++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        chk("rand_beats", 64'(acc), 64'd32000);
        chk("rand_words", 64'(words_out - w0), 64'd8000);

        // Asynchronous reset in the middle of a held word and a partial word.
        out_ready = 1'b0;
        send(8'h10, 1'b0);
        send(8'h20, 1'b0);
        send(8'h30, 1'b0);
        send(8'h40, 1'b0);
        chk("pre_rst_data", 64'(out_data), 64'h40302010);
        send(8'h55, 1'b0);
        send(8'h66, 1'b0);
        #1 reset_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_data", 64'(out_data), 64'd0);
        chk("async_rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        send(8'h04, 1'b0);
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        chk("post_rst_data", 64'(out_data), 64'h04030201);

`ifdef STREAM_PACKER_FLUSH_EN
        // Partial flush after two beats, then a full word.
        send(8'h11, 1'b0);
        send(8'h22, 1'b1);
        chk("flush_valid", 64'(out_valid), 64'd1);
        chk("flush_data", 64'(out_data), 64'h00002211);
        chk("flush_keep", 64'(out_keep), 64'b0011);
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        send(8'h04, 1'b0);
        chk("full_keep", 64'(out_keep), 64'b1111);
        chk("full_data", 64'(out_data), 64'h04030201);
`endif

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
